btn_debounce_multi: RTL

Parametrised multi-channel key debouncer for the game-input path, replacing single-key debounce instances.
- Per channel: synchronises a raw board key and filters bounce with a stability counter.
- Produces a debounced level, one-cycle press and release pulses, and an optional hold-to-repeat pulse train for held move/drop keys.
- Sits between board pins and the game control FSM; all outputs are registered.

---
 rtl/btn_debounce_multi.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/btn_debounce_multi.sv
// Purpose : N_CH-channel key debouncer with press/release pulses and hold-to-repeat.
// Latency : a pin change first sampled at edge E0 flips key_level and pulses at E0+STABLE_CYC+1.
// Backpr. : none; every output is a registered single-cycle pulse or level with no handshake.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   key_in        raw asynchronous key pins (polarity set by ACTIVE_LOW)
//   repeat_en     per-channel auto-repeat enable, sampled every cycle
//   key_level     debounced state, 1 = pressed
//   press_pulse   one cycle at the edge key_level goes 0->1
//   release_pulse one cycle at the edge key_level goes 1->0
//   repeat_pulse  one cycle per auto-repeat while held
//   key_fire      press_pulse | repeat_pulse
//
// CNT_W must cover max(STABLE_CYC, REPEAT_DLY, REPEAT_PER); the terminal
// values are truncated to CNT_W bits, so the default repeat timings need
// CNT_W >= 24 when instantiated.
module btn_debounce_multi #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 18,
    parameter int STABLE_CYC = 250000,
    parameter int REPEAT_DLY = 12500000,
    parameter int REPEAT_PER = 5000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] key_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] key_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic [N_CH-1:0] key_fire
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } rep_state_t;

    // Pin level when the key is not pressed; also the synchroniser reset value.
    localparam logic [N_CH-1:0]  PIN_IDLE    = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST    = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST    = CNT_W'(REPEAT_PER - 1);

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [CNT_W-1:0] cnt   [N_CH];
    logic [CNT_W-1:0] rcnt  [N_CH];
    rep_state_t       state [N_CH];

    logic [N_CH-1:0]  s;            // normalised synchronised key, 1 = pressed
    logic [N_CH-1:0]  flip;         // key_level changes at this edge
    logic [N_CH-1:0]  press_now;
    logic [N_CH-1:0]  release_now;
    logic [N_CH-1:0]  rep_hit;      // repeat pulse issued at this edge

    assign s           = sync2 ^ PIN_IDLE;
    assign press_now   = flip & s;
    assign release_now = flip & ~s;

    always_comb begin
        flip    = '0;
        rep_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            flip[i] = (s[i] != key_level[i]) && (cnt[i] == STABLE_LAST);
            // Release and a falling enable both take priority over a due repeat.
            rep_hit[i] = !release_now[i] && repeat_en[i] &&
                         (((state[i] == DELAY)  && (rcnt[i] == DLY_LAST)) ||
                          ((state[i] == REPEAT) && (rcnt[i] == PER_LAST)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= PIN_IDLE;
            sync2         <= PIN_IDLE;
            key_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
            key_fire      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]   <= '0;
                rcnt[i]  <= '0;
                state[i] <= IDLE;
            end
        end else begin
            sync1         <= key_in;
            sync2         <= sync1;
            press_pulse   <= press_now;
            release_pulse <= release_now;
            repeat_pulse  <= rep_hit;
            key_fire      <= press_now | rep_hit;

            for (int i = 0; i < N_CH; i++) begin
                // Stability counter: any cycle of agreement restarts the count.
                if (s[i] == key_level[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    key_level[i] <= s[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end

                // Repeat FSM.
                case (state[i])
                    IDLE: begin
                        if (press_now[i]) begin
                            state[i] <= repeat_en[i] ? DELAY : LOCK;
                            rcnt[i]  <= '0;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (release_now[i]) begin
                            state[i] <= IDLE;
                            rcnt[i]  <= '0;
                        end else if (!repeat_en[i]) begin
                            // Once locked, repeats only return after a fresh press.
                            state[i] <= LOCK;
                            rcnt[i]  <= '0;
                        end else if (rep_hit[i]) begin
                            state[i] <= REPEAT;
                            rcnt[i]  <= '0;
                        end else begin
                            rcnt[i] <= rcnt[i] + CNT_W'(1);
                        end
                    end
                    LOCK: begin
                        if (release_now[i]) begin
                            state[i] <= IDLE;
                            rcnt[i]  <= '0;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        rcnt[i]  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
